adau_scan: RTL and testbench

Parametrised analog acquisition sequencer for the FDAU board, driven by `clk_5Mhz`. Each `sec` pulse starts one frame:
- emits a sync word;
- walks `N_CH` entries of a mux-setting table;
- for each entry, drives the analog mux, waits for settling, runs `2**AVG_LOG2` ADC conversions and emits their averaged result;
- parks the mux on GND between channels.

Output is a valid/ready word stream tagged with channel index and sync flag, consumed by the UART stream framer.

---
 rtl/adau_scan_if.sv | 25 ++
 rtl/adau_scan.sv | 182 ++++++++++++++++++
 tb/tb_adau_scan.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adau_scan_if.sv
// Word stream carrying averaged samples and frame sync words from the
// acquisition sequencer to the UART stream framer.
interface adau_scan_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_chan;
  logic        out_sync;

  modport master (
    output out_valid,
    output out_data,
    output out_chan,
    output out_sync,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_chan,
    input  out_sync,
    output out_ready
  );
endinterface

// File: rtl/adau_scan.sv
// FDAU analog acquisition sequencer: each sec pulse emits a sync word, then
// for every table entry loads the mux, settles, averages 2**AVG_LOG2 ADC
// conversions, emits the result and parks the mux on GND.
module adau_scan #(
  parameter int          N_CH        = 64,
  parameter int          SETTLE_CLKS = 1220,
  parameter int          PARK_CLKS   = 72,
  parameter int          AVG_LOG2    = 0,
  parameter logic [15:0] SYNC_WORD   = 16'hFF7F
) (
  input  logic        clk_5Mhz,
  input  logic        reset,
  input  logic        sec,
  input  logic        enable,
  output logic [7:0]  tbl_addr,
  input  logic [7:0]  tbl_q,
  output logic [3:0]  ENA,
  output logic [3:0]  ADDR,
  output logic        adc_start,
  input  logic        adc_rdy,
  input  logic [15:0] adc_sample,
  adau_scan_if.master stream,
  output logic        scanning,
  output logic        frame_overrun
);

  localparam int ACC_W   = 16 + AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_CLKS > PARK_CLKS) ? SETTLE_CLKS : PARK_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CLKS - 2);
  localparam logic [CNT_W-1:0] PARK_END   = CNT_W'(PARK_CLKS - 1);
  localparam logic [4:0]       CONV_LAST  = 5'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]       LAST_CH    = 8'(N_CH - 1);
  localparam logic [3:0]       PARK_ENA   = 4'h1;
  localparam logic [3:0]       PARK_ADDR  = 4'hF;

  typedef enum logic [2:0] {
    IDLE, SYNC, PARK, LOAD, SETTLE, CONVERT, EMIT
  } state_t;

  state_t           state, state_n;
  logic [7:0]       ch, ch_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       conv_cnt, conv_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [3:0]       ena_n, addr_n;
  logic             start_n;
  logic             last_emit, last_n;
  logic             overrun_n;

  // Register every piece of sequencer state; reset parks the mux on GND.
  always_ff @(posedge clk_5Mhz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ch            <= '0;
      cnt           <= '0;
      conv_cnt      <= '0;
      acc           <= '0;
      ENA           <= PARK_ENA;
      ADDR          <= PARK_ADDR;
      adc_start     <= 1'b0;
      last_emit     <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_n;
      ch            <= ch_n;
      cnt           <= cnt_n;
      conv_cnt      <= conv_n;
      acc           <= acc_n;
      ENA           <= ena_n;
      ADDR          <= addr_n;
      adc_start     <= start_n;
      last_emit     <= last_n;
      frame_overrun <= overrun_n;
    end
  end

  // Next-state logic; a sec arriving mid-frame overrides everything and restarts at SYNC.
  always_comb begin
    state_n   = state;
    ch_n      = ch;
    cnt_n     = cnt;
    conv_n    = conv_cnt;
    acc_n     = acc;
    ena_n     = ENA;
    addr_n    = ADDR;
    start_n   = adc_start;
    last_n    = last_emit;
    overrun_n = frame_overrun;

    case (state)
      IDLE: begin
        if (sec && enable) begin
          state_n = SYNC;
          ch_n    = '0;
        end
      end
      SYNC: begin
        if (stream.out_ready) state_n = LOAD;
      end
      LOAD: begin
        ena_n   = tbl_q[3:0];
        addr_n  = tbl_q[7:4];
        cnt_n   = '0;
        conv_n  = '0;
        acc_n   = '0;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_END) begin
          state_n = CONVERT;
          start_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CONVERT: begin
        if (adc_start) begin
          if (adc_rdy) begin
            acc_n   = acc + ACC_W'(adc_sample);
            conv_n  = conv_cnt + 5'd1;
            start_n = 1'b0;
            if (conv_cnt == CONV_LAST) begin
              state_n = EMIT;
              ena_n   = PARK_ENA;
              addr_n  = PARK_ADDR;
            end
          end
        end else begin
          start_n = 1'b1;
        end
      end
      EMIT: begin
        if (stream.out_ready) begin
          state_n = PARK;
          cnt_n   = '0;
          last_n  = (ch == LAST_CH);
          if (ch != LAST_CH) ch_n = ch + 8'd1;
        end
      end
      PARK: begin
        if (cnt == PARK_END) begin
          if (last_emit) begin
            state_n = IDLE;
            ch_n    = '0;
          end else begin
            state_n = LOAD;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && sec) begin
      overrun_n = 1'b1;
      start_n   = 1'b0;
      ena_n     = PARK_ENA;
      addr_n    = PARK_ADDR;
      ch_n      = '0;
      cnt_n     = '0;
      conv_n    = '0;
      acc_n     = '0;
      state_n   = SYNC;
    end
  end

  // Stream word and status are decoded straight from the state so reset clears them at once.
  always_comb begin
    stream.out_valid = (state == SYNC) || (state == EMIT);
    stream.out_sync  = (state == SYNC);
    stream.out_chan  = (state == EMIT) ? ch : 8'd0;
    stream.out_data  = 16'd0;
    if (state == SYNC)      stream.out_data = SYNC_WORD;
    else if (state == EMIT) stream.out_data = acc[AVG_LOG2 +: 16];
    scanning = (state != IDLE);
    tbl_addr = ch;
  end

endmodule

// File: tb/tb_adau_scan.sv
// Directed bench for adau_scan: four-entry table, small settle/park times,
// four-conversion averaging, with a simple mux-aware ADC model.
`timescale 1ns/1ps
module tb_adau_scan;

  localparam int N_CH        = 4;
  localparam int SETTLE_CLKS = 6;
  localparam int PARK_CLKS   = 3;
  localparam int AVG_LOG2    = 2;

  logic        clk_5Mhz = 1'b0;
  logic        reset, sec, enable, ready, avg_mode;
  logic [7:0]  tbl_addr, tbl_q;
  logic [3:0]  ENA, ADDR;
  logic        adc_start, adc_rdy;
  logic [15:0] adc_sample;
  logic        scanning, frame_overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tbl_rom [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
  logic [15:0] avg_tab [4] = '{16'd100, 16'd101, 16'd102, 16'd105};

  logic [24:0] stream_q [$];
  logic [7:0]  mux_q [$];
  logic [7:0]  park_q [$];
  int          rise_q [$];
  int          rises_ch = 0;
  int          low_len = 0;
  int          bad_gap = 0;
  logic        start_prev = 1'b0;
  logic        park_pending = 1'b0;

  logic        adc_busy;
  int          adc_wait;

  adau_scan_if bus ();
  assign bus.out_ready = ready;

  adau_scan #(
    .N_CH(N_CH), .SETTLE_CLKS(SETTLE_CLKS), .PARK_CLKS(PARK_CLKS),
    .AVG_LOG2(AVG_LOG2), .SYNC_WORD(16'hFF7F)
  ) dut (
    .clk_5Mhz(clk_5Mhz), .reset(reset), .sec(sec), .enable(enable),
    .tbl_addr(tbl_addr), .tbl_q(tbl_q), .ENA(ENA), .ADDR(ADDR),
    .adc_start(adc_start), .adc_rdy(adc_rdy), .adc_sample(adc_sample),
    .stream(bus.master), .scanning(scanning), .frame_overrun(frame_overrun)
  );

  always #5 clk_5Mhz = ~clk_5Mhz;

  // Synchronous channel table: data follows the address by one clock.
  always @(posedge clk_5Mhz)
    tbl_q <= (tbl_addr < 8'd4) ? tbl_rom[tbl_addr[1:0]] : 8'h00;

  // ADC model: answers about five clocks after a start request.
  always @(posedge clk_5Mhz or posedge reset) begin
    if (reset) begin
      adc_busy   <= 1'b0;
      adc_wait   <= 0;
      adc_rdy    <= 1'b0;
      adc_sample <= 16'h0;
    end else begin
      adc_rdy <= 1'b0;
      if (adc_busy) begin
        if (adc_wait == 1) begin
          adc_rdy    <= 1'b1;
          adc_busy   <= 1'b0;
          adc_sample <= avg_mode ? avg_tab[(rises_ch - 1) & 3] : 16'h1000 + {12'h0, ENA};
        end else begin
          adc_wait <= adc_wait - 1;
        end
      end else if (adc_start && !adc_rdy) begin
        adc_busy <= 1'b1;
        adc_wait <= 5;
      end
    end
  end

  // Stream / mux / start-pulse observer sampled on the falling edge.
  always @(negedge clk_5Mhz) begin
    park_pending <= 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      stream_q.push_back({bus.out_sync, bus.out_chan, bus.out_data});
      if (!bus.out_sync) begin
        rise_q.push_back(rises_ch);
        rises_ch     <= 0;
        park_pending <= 1'b1;
      end
    end else if (park_pending) begin
      park_q.push_back({ENA, ADDR});
    end
    if (adc_start && !start_prev) begin
      if (rises_ch == 0) mux_q.push_back({ENA, ADDR});
      else if (low_len != 1) bad_gap <= bad_gap + 1;
      rises_ch <= rises_ch + 1;
    end
    low_len    <= adc_start ? 0 : low_len + 1;
    start_prev <= adc_start;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en);
    @(posedge clk_5Mhz); #1;
    enable = en;
    sec    = 1'b1;
    @(posedge clk_5Mhz); #1;
    sec = 1'b0;
    @(negedge clk_5Mhz);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (scanning && n < 2000) begin
      @(negedge clk_5Mhz);
      n++;
    end
    checkOutput(tag, {31'd0, scanning}, 32'd0);
  endtask

  task automatic waitMux(input string tag, input logic [3:0] ena, input logic need_start);
    int n = 0;
    while (!(ENA == ena && (!need_start || adc_start)) && n < 2000) begin
      @(negedge clk_5Mhz);
      n++;
    end
    checkOutput(tag, {31'd0, ENA == ena}, 32'd1);
  endtask

  task automatic checkFrame(input string tag, input int base, input logic avg);
    logic [24:0] expw;
    checkOutput({tag, "_len"}, stream_q.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < stream_q.size()) begin
        if (i == 0) expw = {1'b1, 8'd0, 16'hFF7F};
        else        expw = {1'b0, 8'(i - 1), (avg ? 16'd102 : 16'h1000 + 16'(i - 1))};
        checkOutput($sformatf("%s_word%0d", tag, i), {7'd0, stream_q[base + i]}, {7'd0, expw});
      end
    end
  endtask

  task automatic checkRises(input string tag, input int base, input int gap_base);
    checkOutput({tag, "_n"}, rise_q.size() - base, 4);
    for (int i = base; i < rise_q.size(); i++)
      checkOutput($sformatf("%s_ch%0d", tag, i - base), rise_q[i], 4);
    checkOutput({tag, "_gap"}, bad_gap - gap_base, 0);
  endtask

  // Watchdog so a stuck sequencer still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sbase, mbase, pbase, rbase, gbase, n;
    logic [15:0] d0;
    logic stable;

    reset = 1'b1; sec = 1'b0; enable = 1'b1; ready = 1'b1; avg_mode = 1'b0;
    repeat (3) @(negedge clk_5Mhz);
    checkOutput("rst_ena",      {28'd0, ENA},  32'h1);
    checkOutput("rst_addr",     {28'd0, ADDR}, 32'hF);
    checkOutput("rst_start",    {31'd0, adc_start}, 32'd0);
    checkOutput("rst_valid",    {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_data",     {16'd0, bus.out_data}, 32'd0);
    checkOutput("rst_chan",     {24'd0, bus.out_chan}, 32'd0);
    checkOutput("rst_sync",     {31'd0, bus.out_sync}, 32'd0);
    checkOutput("rst_tbl_addr", {24'd0, tbl_addr}, 32'd0);
    checkOutput("rst_scanning", {31'd0, scanning}, 32'd0);
    checkOutput("rst_overrun",  {31'd0, frame_overrun}, 32'd0);
    reset = 1'b0;

    $display("[TB] basic frame");
    sbase = stream_q.size(); mbase = mux_q.size(); pbase = park_q.size();
    rbase = rise_q.size(); gbase = bad_gap;
    applyStimulus(1'b1);
    checkOutput("sync_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("sync_flag",  {31'd0, bus.out_sync}, 32'd1);
    checkOutput("sync_data",  {16'd0, bus.out_data}, 32'hFF7F);
    waitIdle("f1_idle");
    checkFrame("f1", sbase, 1'b0);
    checkOutput("f1_mux_n", mux_q.size() - mbase, 4);
    for (int i = 0; i < 4; i++)
      if (mbase + i < mux_q.size())
        checkOutput($sformatf("f1_mux%0d", i), {24'd0, mux_q[mbase + i]}, {24'd0, 4'(i), 4'(i + 1)});
    checkOutput("f1_park_n", park_q.size() - pbase, 4);
    for (int i = pbase; i < park_q.size(); i++)
      checkOutput($sformatf("f1_park%0d", i - pbase), {24'd0, park_q[i]}, 32'h1F);
    checkRises("f1_starts", rbase, gbase);

    $display("[TB] averaging frame");
    avg_mode = 1'b1;
    sbase = stream_q.size(); rbase = rise_q.size(); gbase = bad_gap;
    applyStimulus(1'b1);
    waitIdle("avg_idle");
    checkFrame("avg", sbase, 1'b1);
    checkRises("avg_starts", rbase, gbase);
    avg_mode = 1'b0;

    $display("[TB] backpressure on ch1");
    sbase = stream_q.size();
    applyStimulus(1'b1);
    n = 0;
    while (!(bus.out_valid && !bus.out_sync && bus.out_chan == 8'd0) && n < 2000) begin
      @(negedge clk_5Mhz); n++;
    end
    checkOutput("bp_ch0_seen", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk_5Mhz); #1;
    ready = 1'b0;
    n = 0;
    while (!(bus.out_valid && !bus.out_sync && bus.out_chan == 8'd1) && n < 2000) begin
      @(negedge clk_5Mhz); n++;
    end
    checkOutput("bp_ch1_seen", {24'd0, bus.out_chan}, 32'd1);
    d0 = bus.out_data;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_data != d0 || bus.out_chan != 8'd1 || !bus.out_valid || adc_start) stable = 1'b0;
      @(negedge clk_5Mhz);
    end
    checkOutput("bp_stable", {31'd0, stable}, 32'd1);
    checkOutput("bp_held_data", {16'd0, bus.out_data}, {16'd0, d0});
    ready = 1'b1;
    n = 0;
    while (ENA != 4'h2 && n < 100) begin
      @(negedge clk_5Mhz); n++;
    end
    checkOutput("bp_load_delay", n, PARK_CLKS + 2);
    waitIdle("bp_idle");
    checkFrame("bp", sbase, 1'b0);

    $display("[TB] overrun during ch2 settle");
    applyStimulus(1'b1);
    waitMux("ov_reach_ch2", 4'h2, 1'b0);
    checkOutput("ov_in_settle", {31'd0, adc_start}, 32'd0);
    sbase = stream_q.size();
    sec = 1'b1;
    @(posedge clk_5Mhz); #1;
    sec = 1'b0;
    @(negedge clk_5Mhz);
    checkOutput("ov_flag",     {31'd0, frame_overrun}, 32'd1);
    checkOutput("ov_sync",     {31'd0, bus.out_sync}, 32'd1);
    checkOutput("ov_data",     {16'd0, bus.out_data}, 32'hFF7F);
    checkOutput("ov_ena",      {28'd0, ENA},  32'h1);
    checkOutput("ov_addr",     {28'd0, ADDR}, 32'hF);
    checkOutput("ov_tbl_addr", {24'd0, tbl_addr}, 32'd0);
    waitIdle("ov_idle");
    checkFrame("ov", sbase, 1'b0);

    $display("[TB] enable gating");
    sbase = stream_q.size();
    applyStimulus(1'b0);
    repeat (10) @(negedge clk_5Mhz);
    checkOutput("dis_scanning", {31'd0, scanning}, 32'd0);
    checkOutput("dis_words", stream_q.size() - sbase, 0);
    checkOutput("dis_overrun_sticky", {31'd0, frame_overrun}, 32'd1);
    sbase = stream_q.size();
    applyStimulus(1'b1);
    repeat (3) @(negedge clk_5Mhz);
    enable = 1'b0;
    waitIdle("drop_idle");
    checkFrame("drop", sbase, 1'b0);
    checkOutput("drop_overrun_sticky", {31'd0, frame_overrun}, 32'd1);

    $display("[TB] reset during convert");
    enable = 1'b1;
    applyStimulus(1'b1);
    waitMux("rc_reach", 4'h2, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rc_start",    {31'd0, adc_start}, 32'd0);
    checkOutput("rc_valid",    {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rc_ena",      {28'd0, ENA},  32'h1);
    checkOutput("rc_addr",     {28'd0, ADDR}, 32'hF);
    checkOutput("rc_tbl_addr", {24'd0, tbl_addr}, 32'd0);
    repeat (2) @(negedge clk_5Mhz);
    reset = 1'b0;
    checkOutput("rc_overrun_clr", {31'd0, frame_overrun}, 32'd0);
    sbase = stream_q.size();
    applyStimulus(1'b1);
    waitIdle("rc_idle");
    checkFrame("rc", sbase, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
